// File: rtl/compare_sweep_checker_if.sv
// compare_sweep_checker_if: control/status and comparator stimulus bundle for compare_sweep_checker
interface compare_sweep_checker_if;
   logic       start;
   logic [3:0] a_out;
   logic [3:0] b_out;
   logic [1:0] cmp_in;
   logic       busy;
   logic       done;
   logic       pass;
   logic [8:0] err_count;
   logic [7:0] first_err;
   modport master (
      output start, cmp_in,
      input  a_out, b_out, busy, done, pass, err_count, first_err
   );
   modport slave (
      input  start, cmp_in,
      output a_out, b_out, busy, done, pass, err_count, first_err
   );
endinterface

// File: rtl/compare_sweep_checker.sv
// compare_sweep_checker: sweeps all 4-bit A/B pairs through an external comparator and counts wrong codes.
// Optional SWEEP_STOP_ON_ERR_EN: finish on the first mismatch with the failing vector frozen.
module compare_sweep_checker #(
   parameter int SETTLE = 1
) (
   input logic                     clk,
   input logic                     rst,
   compare_sweep_checker_if.slave  bus
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_CHECK  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;
   localparam logic [3:0] LAST_WAIT = 4'(SETTLE - 1);
   logic [1:0] state;
   logic [3:0] cnt;
   logic [3:0] a;
   logic [3:0] b;
   logic [8:0] errs;
   logic [7:0] first;
   logic       done_q;
   logic [1:0] exp_code;
   logic       mismatch;
   logic       last;
   logic       stop;
   always_comb begin
      exp_code = (a > b) ? 2'b01 : (a < b) ? 2'b10 : 2'b11;
      mismatch = (bus.cmp_in == 2'b00) || (bus.cmp_in != exp_code);
      last     = (a == 4'd15) && (b == 4'd15);
`ifdef SWEEP_STOP_ON_ERR_EN
      stop     = last || mismatch;
`else
      stop     = last;
`endif
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         a      <= '0;
         b      <= '0;
         errs   <= '0;
         first  <= '0;
         done_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  a      <= '0;
                  b      <= '0;
                  cnt    <= '0;
                  errs   <= '0;
                  first  <= '0;
                  done_q <= 1'b0;
                  state  <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               cnt <= cnt + 4'd1;
               if (cnt == LAST_WAIT) state <= S_CHECK;
            end
            S_CHECK: begin
               if (mismatch) begin
                  if (errs != 9'd256) errs <= errs + 9'd1;
                  if (errs == 9'd0) first <= {a, b};
               end
               // b is the low half of the vector, so a carries on b wrapping
               if (stop) begin
                  state  <= S_DONE;
                  done_q <= 1'b1;
               end else begin
                  {a, b} <= {a, b} + 8'd1;
                  cnt    <= '0;
                  state  <= S_SETTLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
   assign bus.a_out     = a;
   assign bus.b_out     = b;
   assign bus.busy      = (state == S_SETTLE) || (state == S_CHECK);
   assign bus.done      = done_q;
   assign bus.pass      = done_q && (errs == 9'd0);
   assign bus.err_count = errs;
   assign bus.first_err = first;
endmodule

// File: tb/tb_compare_sweep_checker.sv
// tb_compare_sweep_checker: two checkers (SETTLE=1 and SETTLE=3) against a comparator model with injectable faults.
module tb_compare_sweep_checker;
   logic clk = 1'b0;
   logic rst;
   logic start;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;
   compare_sweep_checker_if bus1 ();
   compare_sweep_checker_if bus3 ();
   compare_sweep_checker #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   compare_sweep_checker #(.SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
   // bad[v] marks vectors {a,b} where the comparator answers wrong[v] instead of the true code
   logic       bad   [256];
   logic [1:0] wrong [256];
   assign bus1.start = start;
   assign bus3.start = start;
   always_comb begin
      bus1.cmp_in = bad[{bus1.a_out, bus1.b_out}] ? wrong[{bus1.a_out, bus1.b_out}] :
                    (bus1.a_out > bus1.b_out) ? 2'b01 : (bus1.a_out < bus1.b_out) ? 2'b10 : 2'b11;
      bus3.cmp_in = bad[{bus3.a_out, bus3.b_out}] ? wrong[{bus3.a_out, bus3.b_out}] :
                    (bus3.a_out > bus3.b_out) ? 2'b01 : (bus3.a_out < bus3.b_out) ? 2'b10 : 2'b11;
   end
   int         sv [2] = '{1, 3};
   logic [3:0] oa [2];
   logic [3:0] ob [2];
   logic       obusy [2];
   logic       odone [2];
   logic       opass [2];
   logic [8:0] oerr [2];
   logic [7:0] ofirst [2];
   task automatic sample();
      oa[0] = bus1.a_out;  ob[0] = bus1.b_out;  obusy[0] = bus1.busy;  odone[0] = bus1.done;
      opass[0] = bus1.pass; oerr[0] = bus1.err_count; ofirst[0] = bus1.first_err;
      oa[1] = bus3.a_out;  ob[1] = bus3.b_out;  obusy[1] = bus3.busy;  odone[1] = bus3.done;
      opass[1] = bus3.pass; oerr[1] = bus3.err_count; ofirst[1] = bus3.first_err;
   endtask
   // m: 0 correct, 1 gt/lt swapped, 2 stuck at 00, 3 random wrong codes
   task automatic set_mode(input int m);
      for (int i = 0; i < 256; i++) begin
         int va = i / 16;
         int vb = i % 16;
         logic [1:0] tc = (va > vb) ? 2'b01 : (va < vb) ? 2'b10 : 2'b11;
         case (m)
            0: begin bad[i] = 1'b0; wrong[i] = 2'b00; end
            1: begin bad[i] = (va != vb); wrong[i] = {tc[0], tc[1]}; end
            2: begin bad[i] = 1'b1; wrong[i] = 2'b00; end
            default: begin
               bad[i]   = ($urandom_range(0, 11) == 0);
               wrong[i] = tc ^ 2'($urandom_range(1, 3));
            end
         endcase
      end
   endtask
   // expected totals from the fault map: error count, first failing vector, done latency, last vector
   task automatic model(input int s, output int e_err, output int e_first, output int e_time, output int e_fin);
      int nbad = 0;
      int fidx = -1;
      for (int i = 0; i < 256; i++) if (bad[i]) begin
         nbad++;
         if (fidx < 0) fidx = i;
      end
      e_first = (fidx < 0) ? 0 : fidx;
`ifdef SWEEP_STOP_ON_ERR_EN
      if (fidx >= 0) begin
         e_err = 1; e_time = (fidx + 1) * (s + 1); e_fin = fidx;
         return;
      end
`endif
      e_err = nbad; e_time = 256 * (s + 1); e_fin = 255;
   endtask
   task automatic run_sweep(input string name, input int extra);
      int et [2];
      int ee [2];
      int ef [2];
      int efin [2];
      int t [2] = '{0, 0};
      int seqbad [2] = '{0, 0};
      for (int d = 0; d < 2; d++) model(sv[d], ee[d], ef[d], et[d], efin[d]);
      @(negedge clk) start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      sample();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({obusy[d], odone[d], oerr[d], ofirst[d], oa[d], ob[d]} !== {1'b1, 1'b0, 9'd0, 8'd0, 4'd0, 4'd0}) begin
            errors++;
            $display("FAIL %s accept S=%0d: busy=%0d done=%0d err=%0d first=%0h a=%0d b=%0d, want busy=1 rest 0",
                     name, sv[d], obusy[d], odone[d], oerr[d], ofirst[d], oa[d], ob[d]);
         end
      end
      for (int cyc = 1; cyc <= 1100 && (t[0] == 0 || t[1] == 0); cyc++) begin
         start = (cyc == extra);
         @(posedge clk); #1;
         sample();
         for (int d = 0; d < 2; d++) if (t[d] == 0) begin
            int v = cyc / (sv[d] + 1);
            if (v > efin[d]) v = efin[d];
            if (odone[d]) t[d] = cyc;
            if ({oa[d], ob[d]} != 8'(v) || obusy[d] == odone[d]) seqbad[d]++;
         end
      end
      start = 1'b0;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (t[d] != et[d]) begin
            errors++;
            $display("FAIL %s latency S=%0d: got %0d cycles (0=timeout), want %0d", name, sv[d], t[d], et[d]);
         end
         checks++;
         if (seqbad[d] != 0) begin
            errors++;
            $display("FAIL %s sequence S=%0d: %0d bad cycles, want 0", name, sv[d], seqbad[d]);
         end
         checks++;
         if (oerr[d] !== 9'(ee[d])) begin
            errors++;
            $display("FAIL %s err_count S=%0d: got %0d, want %0d", name, sv[d], oerr[d], ee[d]);
         end
         checks++;
         if (ofirst[d] !== 8'(ef[d])) begin
            errors++;
            $display("FAIL %s first_err S=%0d: got %0h, want %0h", name, sv[d], ofirst[d], ef[d]);
         end
         checks++;
         if (opass[d] !== (ee[d] == 0) || odone[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s pass/done S=%0d: pass=%0d done=%0d, want pass=%0d done=1",
                     name, sv[d], opass[d], odone[d], ee[d] == 0);
         end
         checks++;
         if ({oa[d], ob[d]} !== 8'(efin[d])) begin
            errors++;
            $display("FAIL %s final vector S=%0d: got %0h, want %0h", name, sv[d], {oa[d], ob[d]}, efin[d]);
         end
      end
   endtask
   task automatic check_zero(input string name);
      sample();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({obusy[d], odone[d], opass[d], oerr[d], ofirst[d], oa[d], ob[d]} !== '0) begin
            errors++;
            $display("FAIL %s S=%0d: busy=%0d done=%0d pass=%0d err=%0d first=%0h a=%0d b=%0d, want all 0",
                     name, sv[d], obusy[d], odone[d], opass[d], oerr[d], ofirst[d], oa[d], ob[d]);
         end
      end
   endtask
   task automatic release_reset();
      @(posedge clk) #2 rst = 1'b0;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      set_mode(0);
      repeat (3) @(posedge clk);
      #1 check_zero("reset");
      release_reset();
   endtask
   task automatic test_clean();
      set_mode(0);
      run_sweep("clean", 0);
   endtask
   task automatic test_swapped();
      set_mode(1);
      run_sweep("swapped", 0);
   endtask
   task automatic test_tied_zero();
      set_mode(2);
      run_sweep("tied00", 0);
   endtask
   task automatic test_random();
      for (int k = 0; k < 3; k++) begin
         set_mode(3);
         run_sweep("random", 0);
      end
   endtask
   task automatic test_start_while_busy();
      set_mode(0);
      run_sweep("busy_start_100", 100);
      run_sweep("busy_start_3", 3);
   endtask
   task automatic test_back_to_back();
      set_mode(1);
      run_sweep("b2b_first", 0);
      set_mode(0);
      run_sweep("b2b_second", 0);
   endtask
   task automatic test_mid_reset();
      bit found = 0;
      set_mode(0);
      @(negedge clk) start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      for (int cyc = 0; cyc < 400 && !found; cyc++) begin
         @(posedge clk); #1;
         if (bus1.a_out == 4'd5 && bus1.b_out == 4'd9) found = 1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL mid_reset reach: vector a=5 b=9 seen=%0d, want 1", found);
      end
      #2 rst = 1'b1;
      #1 check_zero("mid_reset async");
      release_reset();
      run_sweep("after_reset", 0);
   endtask
   initial begin
      test_reset();
      test_clean();
      test_swapped();
      test_tied_zero();
      test_random();
      test_start_while_busy();
      test_back_to_back();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
